// File: rtl/mmio_io_ctrl_if.sv
// CPU data-port bus between the core and the memory-mapped I/O controller.
// Also carries the interrupt handshake.
interface mmio_io_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] w_data;
    logic              w_en;
    logic              hit;
    logic [DATA_W-1:0] r_data;
    logic              cpu_int_en;
    logic              int_req;
    logic [DATA_W-1:0] int_vec;

    // CPU side drives the address, data and strobes.
    modport master (
        output addr, w_data, w_en, cpu_int_en,
        input  hit, r_data, int_req, int_vec
    );

    // Controller side decodes the window and raises interrupts.
    modport slave (
        input  addr, w_data, w_en, cpu_int_en,
        output hit, r_data, int_req, int_vec
    );
endinterface

// File: rtl/mmio_io_ctrl.sv
// Memory-mapped I/O controller: N_GPIO byte-wide GPIO ports and an N_IRQ-source
// edge-triggered interrupt controller (mask, sticky pending, fixed priority,
// per-source vector, EOI via write to CAUSE).
module mmio_io_ctrl #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 'hE0,
    parameter int N_GPIO    = 2,
    parameter int N_IRQ     = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    mmio_io_ctrl_if.slave              bus,
    output logic [N_GPIO*DATA_W-1:0]   gpio_out,
    input  logic [N_GPIO*DATA_W-1:0]   gpio_in,
    input  logic [N_IRQ-1:0]           irq_src
);

    localparam int WIN  = 4 + 2 * N_GPIO;
    localparam int ID_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

    // Architectural registers
    logic [N_IRQ-1:0]         r_en;
    logic [N_IRQ-1:0]         r_pend;
    logic [DATA_W-1:0]        r_vec_base;
    logic [N_GPIO*DATA_W-1:0] r_gpio_out;
    logic [N_GPIO*DATA_W-1:0] r_sync1;
    logic [N_GPIO*DATA_W-1:0] r_sync2;
    logic [N_IRQ-1:0]         r_src_q;
    logic [0:0]               r_state;
    logic [ID_W-1:0]          r_id;
    logic                     r_int_req;
    logic [DATA_W-1:0]        r_int_vec;

    // Decode and datapath nets
    logic [ADDR_W-1:0]        w_off;
    logic                     w_hit;
    logic                     w_wr;
    logic                     w_wr_en;
    logic                     w_wr_pend;
    logic                     w_wr_vb;
    logic                     w_wr_cause;
    logic [N_IRQ-1:0]         w_set;
    logic [N_IRQ-1:0]         w_clr_w1c;
    logic [N_IRQ-1:0]         w_clr_svc;
    logic [N_IRQ-1:0]         w_ready;
    logic                     w_take;
    logic [ID_W-1:0]          w_sel_id;
    logic [DATA_W-1:0]        w_sel_vec;
    logic [DATA_W-1:0]        w_cause;
    logic [DATA_W-1:0]        w_rd;

    // Offset wraps for addresses below the base, so one compare covers both ends.
    assign w_off      = bus.addr - ADDR_W'(BASE_ADDR);
    assign w_hit      = (w_off < ADDR_W'(WIN));
    assign w_wr       = bus.w_en & w_hit;
    assign w_wr_en    = w_wr & (w_off == ADDR_W'(0));
    assign w_wr_pend  = w_wr & (w_off == ADDR_W'(1));
    assign w_wr_vb    = w_wr & (w_off == ADDR_W'(2));
    assign w_wr_cause = w_wr & (w_off == ADDR_W'(3));

    assign w_set     = irq_src & ~r_src_q;
    assign w_ready   = r_pend & r_en;
    assign w_take    = (r_state == ST_IDLE) & bus.cpu_int_en & (|w_ready);
    assign w_clr_w1c = w_wr_pend ? bus.w_data[N_IRQ-1:0] : '0;
    assign w_clr_svc = w_take ? (N_IRQ'(1) << w_sel_id) : '0;
    assign w_sel_vec = r_vec_base + (DATA_W'(w_sel_id) << 1);

    // Fixed priority: lowest-index enabled pending source wins.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_sel_id = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (w_ready[i]) begin
                w_sel_id = ID_W'(i);
            end
        end
    end

    // CAUSE view: active flag in the MSB, source id in the low bits.
    always_comb begin
        w_cause                = '0;
        w_cause[DATA_W-1]      = (r_state == ST_ACTIVE);
        w_cause[ID_W-1:0]      = r_id;
    end

    // Combinational read mux; anything outside the window reads 0.
    always_comb begin
        w_rd = '0;
        if (w_hit) begin
            if (w_off == ADDR_W'(0)) begin
                w_rd = DATA_W'(r_en);
            end else if (w_off == ADDR_W'(1)) begin
                w_rd = DATA_W'(r_pend);
            end else if (w_off == ADDR_W'(2)) begin
                w_rd = r_vec_base;
            end else if (w_off == ADDR_W'(3)) begin
                w_rd = w_cause;
            end
            for (int k = 0; k < N_GPIO; k++) begin
                if (w_off == ADDR_W'(4 + 2 * k)) begin
                    w_rd = r_gpio_out[k*DATA_W +: DATA_W];
                end
                if (w_off == ADDR_W'(5 + 2 * k)) begin
                    w_rd = r_sync2[k*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Control registers: interrupt mask and vector base.
    always_ff @(posedge clock or posedge reset) begin
        // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            r_en       <= '0;
            r_vec_base <= '0;
        end else begin
            if (w_wr_en) begin
                r_en <= bus.w_data[N_IRQ-1:0];
            end
            if (w_wr_vb) begin
                r_vec_base <= bus.w_data;
            end
        end
    end

    // GPIO output registers, one byte lane per port.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_gpio_out <= '0;
        end else if (w_wr) begin
            for (int k = 0; k < N_GPIO; k++) begin
                if (w_off == ADDR_W'(4 + 2 * k)) begin
                    r_gpio_out[k*DATA_W +: DATA_W] <= bus.w_data;
                end
            end
        end
    end

    // Two-flop synchroniser on the asynchronous GPIO inputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= gpio_in;
            r_sync2 <= r_sync1;
        end
    end

    // Source history and sticky pending bits; a new edge beats any clear in the same cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_src_q <= '0;
            r_pend  <= '0;
        end else begin
            r_src_q <= irq_src;
            r_pend  <= (r_pend & ~w_clr_w1c & ~w_clr_svc) | w_set;
        end
    end

    // Service FSM: issue one request, latch id/vector, wait for EOI.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_int_req <= 1'b0;
            r_id      <= '0;
            r_int_vec <= '0;
        end else begin
            r_int_req <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_take) begin
                        r_int_req <= 1'b1;
                        r_id      <= w_sel_id;
                        r_int_vec <= w_sel_vec;
                        r_state   <= ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (w_wr_cause) begin
                        r_id    <= '0;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.hit     = w_hit;
    assign bus.r_data  = w_rd;
    assign bus.int_req = r_int_req;
    assign bus.int_vec = r_int_vec;
    assign gpio_out    = r_gpio_out;

endmodule

// File: tb/tb_mmio_io_ctrl.sv
// Self-checking bench for mmio_io_ctrl: directed scenarios with literal
// expectations plus randomized traffic compared against a behavioural model.
module tb_mmio_io_ctrl;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 8;
    localparam int BASE   = 'hE0;
    localparam int N_GPIO = 2;
    localparam int N_IRQ  = 4;
    localparam int WIN    = 4 + 2 * N_GPIO;

    logic                      clock = 1'b0;
    logic                      reset = 1'b0;
    logic [N_GPIO*DATA_W-1:0]  gpio_out;
    logic [N_GPIO*DATA_W-1:0]  gpio_in = '0;
    logic [N_IRQ-1:0]          irq_src = '0;

    int total = 0;
    int bad   = 0;

    mmio_io_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    mmio_io_ctrl #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BASE_ADDR(BASE),
        .N_GPIO(N_GPIO), .N_IRQ(N_IRQ)
    ) dut (
        .clock(clock), .reset(reset), .bus(bus),
        .gpio_out(gpio_out), .gpio_in(gpio_in), .irq_src(irq_src)
    );

    always #5 clock = ~clock;

    // Behavioural model state
    logic [N_IRQ-1:0]         m_en = '0;
    logic [N_IRQ-1:0]         m_pend = '0;
    logic [N_IRQ-1:0]         m_src_q = '0;
    logic [7:0]               m_vb = '0;
    logic [7:0]               m_vec = '0;
    logic [7:0]               m_gpio [N_GPIO] = '{default: '0};
    logic [N_GPIO*DATA_W-1:0] m_pins_prev = '0;
    logic [N_GPIO*DATA_W-1:0] m_pins_prev2 = '0;
    logic                     m_active = 1'b0;
    logic                     m_req = 1'b0;
    int                       m_id = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic bit in_window(input logic [7:0] a);
        return (int'(a) >= BASE) && (int'(a) < BASE + WIN);
    endfunction

    function automatic int lowest(input logic [N_IRQ-1:0] v);
        for (int i = 0; i < N_IRQ; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Offset of the write happening this cycle, -1 when none.
    function automatic int wr_off();
        if (bus.w_en && in_window(bus.addr)) return int'(bus.addr) - BASE;
        return -1;
    endfunction

    // Source that the controller accepts at this edge, -1 when none.
    function automatic int service_id();
        if (m_active || !bus.cpu_int_en) return -1;
        return lowest(m_pend & m_en);
    endfunction

    function automatic logic [N_IRQ-1:0] next_pend(input logic [N_IRQ-1:0] cur,
                                                   input logic [N_IRQ-1:0] rose,
                                                   input logic [N_IRQ-1:0] w1c,
                                                   input int served);
        logic [N_IRQ-1:0] n;
        for (int i = 0; i < N_IRQ; i++) begin
            if (rose[i])                  n[i] = 1'b1;
            else if (w1c[i] || i == served) n[i] = 1'b0;
            else                          n[i] = cur[i];
        end
        return n;
    endfunction

    function automatic logic [N_IRQ-1:0] w1c_mask();
        if (wr_off() == 1) return bus.w_data[N_IRQ-1:0];
        return '0;
    endfunction

    function automatic logic [7:0] exp_rdata(input logic [7:0] a);
        int off;
        if (!in_window(a)) return 8'h00;
        off = int'(a) - BASE;
        case (off)
            0: return 8'(m_en);
            1: return 8'(m_pend);
            2: return m_vb;
            3: return m_active ? 8'(8'h80 | m_id) : 8'h00;
            default: begin
                if (off % 2 == 0) return m_gpio[(off - 4) / 2];
                return m_pins_prev2[((off - 5) / 2) * 8 +: 8];
            end
        endcase
    endfunction

    function automatic logic [N_GPIO*DATA_W-1:0] exp_gpio();
        logic [N_GPIO*DATA_W-1:0] r;
        for (int k = 0; k < N_GPIO; k++) r[k*8 +: 8] = m_gpio[k];
        return r;
    endfunction

    // Model update at each edge, computed from the register-map rules.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_en <= '0; m_pend <= '0; m_src_q <= '0; m_vb <= '0; m_vec <= '0;
            m_pins_prev <= '0; m_pins_prev2 <= '0; m_active <= 1'b0; m_req <= 1'b0; m_id <= 0;
            for (int k = 0; k < N_GPIO; k++) m_gpio[k] <= '0;
        end else begin
            m_src_q      <= irq_src;
            m_pins_prev  <= gpio_in;
            m_pins_prev2 <= m_pins_prev;
            m_req        <= 1'b0;
            m_pend       <= next_pend(m_pend, irq_src & ~m_src_q, w1c_mask(), service_id());
            case (wr_off())
                0: m_en <= bus.w_data[N_IRQ-1:0];
                2: m_vb <= bus.w_data;
                3: if (m_active) m_active <= 1'b0;
                default: if (wr_off() >= 4 && wr_off() % 2 == 0) m_gpio[(wr_off() - 4) / 2] <= bus.w_data;
            endcase
            if (service_id() >= 0) begin
                m_req    <= 1'b1;
                m_active <= 1'b1;
                m_id     <= service_id();
                m_vec    <= 8'(int'(m_vb) + 2 * service_id());
            end
        end
    end

    // Compare process: every cycle, away from the active edge.
    always begin
        @(negedge clock);
        #2;
        check("hit", 32'(bus.hit), 32'(in_window(bus.addr)));
        check("r_data", 32'(bus.r_data), 32'(exp_rdata(bus.addr)));
        check("gpio_out", 32'(gpio_out), 32'(exp_gpio()));
        check("int_req", 32'(bus.int_req), 32'(m_req));
        check("int_vec", 32'(bus.int_vec), 32'(m_vec));
    end

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
        bus.addr   = a;
        bus.w_data = d;
        bus.w_en   = 1'b1;
        @(negedge clock);
        bus.w_en   = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, output logic [7:0] v);
        bus.addr = a;
        #1;
        v = bus.r_data;
    endtask

    initial begin
        logic [7:0] v;
        bus.addr = '0; bus.w_data = '0; bus.w_en = 1'b0; bus.cpu_int_en = 1'b0;
        #1 reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;

        // Reset state
        check("rst int_req", 32'(bus.int_req), 32'h0);
        check("rst int_vec", 32'(bus.int_vec), 32'h0);
        rd(8'hE3, v); check("rst cause", 32'(v), 32'h0);
        tick();

        // GPIO out write and synchronised input read
        bus_write(8'hE4, 8'hA5);
        check("gpio_out lane0", 32'(gpio_out), 32'h00A5);
        gpio_in = 16'h3C00;
        rd(8'hE7, v); check("gpio_in 0 edges", 32'(v), 32'h00);
        tick();
        rd(8'hE7, v); check("gpio_in 1 edge", 32'(v), 32'h00);
        tick();
        rd(8'hE7, v); check("gpio_in 2 edges", 32'(v), 32'h3C);

        // Two sources in one cycle: priority, vector, cause, EOI
        bus_write(8'hE0, 8'h0F);
        bus_write(8'hE2, 8'h40);
        irq_src = 4'b1010; bus.cpu_int_en = 1'b1;
        tick();
        irq_src = 4'b0000;
        tick();
        check("t3 int_req", 32'(bus.int_req), 32'h1);
        check("t3 int_vec", 32'(bus.int_vec), 32'h42);
        rd(8'hE3, v); check("t3 cause", 32'(v), 32'h81);
        rd(8'hE1, v); check("t3 pend", 32'(v), 32'h08);
        tick();
        check("t3 no nest", 32'(bus.int_req), 32'h0);
        bus_write(8'hE3, 8'h00);
        check("t3 eoi cycle", 32'(bus.int_req), 32'h0);
        tick();
        check("t3 second req", 32'(bus.int_req), 32'h1);
        check("t3 second vec", 32'(bus.int_vec), 32'h46);
        bus_write(8'hE3, 8'h00);

        // Masked source stays pending until unmasked
        bus_write(8'hE0, 8'h00);
        irq_src = 4'b0100;
        tick();
        irq_src = 4'b0000;
        tick();
        rd(8'hE1, v); check("t4 pend", 32'(v), 32'h04);
        check("t4 masked", 32'(bus.int_req), 32'h0);
        bus_write(8'hE0, 8'h04);
        check("t4 unmask edge", 32'(bus.int_req), 32'h0);
        tick();
        check("t4 req", 32'(bus.int_req), 32'h1);
        check("t4 vec", 32'(bus.int_vec), 32'h44);
        bus_write(8'hE3, 8'h00);

        // W1C colliding with a new edge: set wins
        bus_write(8'hE0, 8'h00);
        irq_src = 4'b0001;
        tick();
        irq_src = 4'b0000;
        tick();
        irq_src = 4'b0001;
        bus_write(8'hE1, 8'h01);
        irq_src = 4'b0000;
        rd(8'hE1, v); check("t5 set wins", 32'(v), 32'h01);
        tick();
        bus_write(8'hE1, 8'h01);
        rd(8'hE1, v); check("t5 w1c", 32'(v), 32'h00);

        // Vector wrap and out-of-window read, then reset while ACTIVE
        bus_write(8'hE2, 8'hFE);
        bus_write(8'hE0, 8'h0F);
        irq_src = 4'b0110;
        tick();
        irq_src = 4'b0000;
        tick();
        check("t6 req", 32'(bus.int_req), 32'h1);
        check("t6 wrap vec", 32'(bus.int_vec), 32'h00);
        rd(8'hDF, v);
        check("t6 hit below", 32'(bus.hit), 32'h0);
        check("t6 r_data below", 32'(v), 32'h00);
        #2 reset = 1'b1;
        #1;
        check("t1 req", 32'(bus.int_req), 32'h0);
        check("t1 gpio", 32'(gpio_out), 32'h0000);
        tick();
        rd(8'hE3, v); check("t1 cause", 32'(v), 32'h00);
        rd(8'hE1, v); check("t1 pend", 32'(v), 32'h00);
        tick();
        reset = 1'b0;

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            bus.addr       = 8'(BASE - 2 + int'($urandom_range(0, WIN + 3)));
            bus.w_en       = ($urandom_range(0, 3) == 0);
            bus.w_data     = 8'($urandom);
            bus.cpu_int_en = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) == 0) irq_src = N_IRQ'($urandom);
            if ($urandom_range(0, 7) == 0) gpio_in = 16'($urandom);
            if ($urandom_range(0, 499) == 0) #3 reset = 1'b1;
            @(negedge clock);
            reset = 1'b0;
        end

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
